// File: rtl/sd_mag_pkg.sv
// Shared helpers and FSM encoding for the multi-channel sigma-delta magnitude estimator.
package sd_mag_pkg;

    // Index width for n items, never narrower than one bit.
    function automatic int ch_bits(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    function automatic int fs(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/sd_mag_channel.sv
// One channel: bipolar leaky integrator, rectifier, second leaky integrator.
// With SD_MAG_PEAK_EN defined a window peak register feeds the snapshot.
module sd_mag_channel
    import sd_mag_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GAIN  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic             sd,
    output logic [WIDTH-1:0] snap
);
    localparam int AW = WIDTH + GAIN;
    localparam int BW = WIDTH - 1 + GAIN;
    localparam logic signed [AW-1:0] FS_A     = AW'(fs(WIDTH));
    localparam logic signed [AW-1:0] NEG_FS_A = -FS_A;
    localparam logic [WIDTH-2:0]     FS_M     = (WIDTH-1)'(fs(WIDTH));

    logic signed [AW-1:0] a_r;
    logic signed [AW-1:0] x_s;
    logic signed [AW-1:0] e_s;
    logic signed [AW-1:0] abs_s;
    logic [WIDTH-2:0]     m_s;
    logic [BW-1:0]        b_r;
    logic [WIDTH-1:0]     mag_s;

    // Stage-1 output rectified and clamped to full scale.
    always_comb begin
        x_s = sd ? FS_A : NEG_FS_A;
        e_s = a_r >>> GAIN;
        if (e_s[AW-1]) begin
            abs_s = -e_s;
        end else begin
            abs_s = e_s;
        end
        if (abs_s > FS_A) begin
            m_s = FS_M;
        end else begin
            m_s = abs_s[WIDTH-2:0];
        end
        mag_s = {1'b0, b_r[BW-1:GAIN]};
    end

    // Both integrators; intermediate sums may wrap but each final result fits.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= {AW{1'b0}};
            b_r <= {BW{1'b0}};
        end else if (en) begin
            a_r <= a_r + x_s - (a_r >>> GAIN);
            b_r <= b_r + {{GAIN{1'b0}}, m_s} - (b_r >> GAIN);
        end
    end

`ifdef SD_MAG_PEAK_EN
    logic [WIDTH-1:0] peak_r;
    logic [WIDTH-1:0] pmax_s;

    // Running maximum including the value about to be captured.
    always_comb begin
        if (mag_s > peak_r) begin
            pmax_s = mag_s;
        end else begin
            pmax_s = peak_r;
        end
    end

    // Peak restarts at every window boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_r <= {WIDTH{1'b0}};
        end else if (en) begin
            peak_r <= wrap ? {WIDTH{1'b0}} : pmax_s;
        end
    end

    assign snap = pmax_s;
`else
    logic wrap_unused_s;
    assign wrap_unused_s = wrap;
    assign snap = mag_s;
`endif

endmodule

// File: rtl/sd_magnitude_multi.sv
// Multi-channel sigma-delta magnitude estimator with decimated, serialised output.
// Optional window-peak reporting via SD_MAG_PEAK_EN.
module sd_magnitude_multi
    import sd_mag_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int GAIN     = 6,
    parameter int DECIM    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CHANNELS-1:0]           in,
    output logic [WIDTH-1:0]              out,
    output logic [ch_bits(CHANNELS)-1:0]  outChan,
    output logic                          outValid,
    input  logic                          outReady,
    output logic                          overrun
);
    localparam int CH_BITS  = ch_bits(CHANNELS);
    localparam int CNT_BITS = ch_bits(DECIM);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DECIM - 1);
    localparam logic [CH_BITS-1:0]  IDX_LAST = CH_BITS'(CHANNELS - 1);

    logic [CNT_BITS-1:0] cnt_r;
    logic                wrap_s;
    logic                capture_s;
    logic [WIDTH-1:0]    snap_s [CHANNELS];
    logic [WIDTH-1:0]    bank_r [CHANNELS];
    state_t              state_r;
    state_t              state_s;
    logic [CH_BITS-1:0]  idx_r;
    logic [CH_BITS-1:0]  idx_s;
    logic [WIDTH-1:0]    out_s;
    logic [CH_BITS-1:0]  chan_s;
    logic                valid_s;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        sd_mag_channel #(
            .WIDTH (WIDTH),
            .GAIN  (GAIN)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .wrap  (wrap_s),
            .sd    (in[k]),
            .snap  (snap_s[k])
        );
    end

    assign wrap_s    = en && (cnt_r == CNT_LAST);
    assign capture_s = wrap_s && (state_r == IDLE);

    // Next-state and next-output logic; the first word bypasses the bank.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        out_s   = out;
        chan_s  = outChan;
        valid_s = outValid;
        case (state_r)
            IDLE: begin
                if (wrap_s) begin
                    state_s = SEND;
                    idx_s   = {CH_BITS{1'b0}};
                    out_s   = snap_s[0];
                    chan_s  = {CH_BITS{1'b0}};
                    valid_s = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            SEND: begin
                if (outValid && outReady) begin
                    if (idx_r == IDX_LAST) begin
                        state_s = IDLE;
                        valid_s = 1'b0;
                    end else begin
                        idx_s  = idx_r + 1'b1;
                        out_s  = bank_r[idx_s];
                        chan_s = idx_s;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, outputs, decimation counter, snapshot bank and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= {CH_BITS{1'b0}};
            out      <= {WIDTH{1'b0}};
            outChan  <= {CH_BITS{1'b0}};
            outValid <= 1'b0;
            overrun  <= 1'b0;
            cnt_r    <= {CNT_BITS{1'b0}};
            for (int k = 0; k < CHANNELS; k++) begin
                bank_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            out      <= out_s;
            outChan  <= chan_s;
            outValid <= valid_s;
            if (en) begin
                cnt_r <= wrap_s ? {CNT_BITS{1'b0}} : cnt_r + 1'b1;
            end
            if (wrap_s && (state_r == SEND)) begin
                overrun <= 1'b1;
            end
            if (capture_s) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    bank_r[k] <= snap_s[k];
                end
            end
        end
    end

endmodule

// File: doc/sd_magnitude_multi.md
Name: sd_magnitude_multi

Overview:
- Multi-channel successor to the single-channel sigma-delta magnitude estimator.
- Takes CHANNELS parallel 1-bit sigma-delta streams and runs a two-stage leaky-integrator magnitude estimate per channel.
- Snapshots all magnitudes every DECIM enabled cycles and serialises them onto one valid/ready output stream tagged with the channel index.
- Sits between the modulator/ADC front end and downstream level-metering or AGC logic.

Parameters:
- CHANNELS, 4: number of independent sigma-delta inputs (1..16).
- WIDTH, 16: magnitude output width; full scale FS = 2^(WIDTH-1)-1.
- GAIN, 6: leaky-integrator shift; time constant is 2^GAIN enabled cycles.
- DECIM, 64: enabled cycles per snapshot (>= CHANNELS+1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, active high & synchronous
- en  input  1  enable (use to clock at slower rate); gates filters and decimation counter only
- in  input  CHANNELS  sigma-delta bits, bit k = channel k
- out  output  WIDTH  magnitude of channel outChan, unsigned
- outChan  output  CH_BITS  channel index of out
- outValid  output  1  out/outChan valid
- outReady  input  1  downstream accepts when outValid&outReady
- overrun  output  1  sticky; a snapshot was dropped

Behaviour:
- Reset: all accumulators, decimation counter, snapshot bank, out, outChan, outValid and overrun are 0; the FSM goes to IDLE. Reset mid-SEND discards the pending snapshot, and outValid is 0 the cycle after rst.
- Stage 1, per channel, on en=1:
  - x = +FS if bit is 1, else -FS.
  - a (signed, WIDTH+GAIN bits) <= a + x - (a >>> GAIN).
  - e = a >>> GAIN.
- Stage 2, per channel:
  - m = |e|, saturated to FS.
  - b (unsigned, WIDTH-1+GAIN bits) <= b + m - (b >> GAIN).
  - mag = b >> GAIN, zero-extended to WIDTH.
- Constant all-ones input settles at mag = FS.
- Decimation counter:
  - Counts 0..DECIM-1 on en=1 and wraps to 0.
  - At the edge where en=1 and count==DECIM-1 ("wrap"), the snapshot bank captures all current registered mag values.
  - If the FSM is IDLE, it moves to SEND with index 0.
- FSM IDLE/SEND:
  - In SEND: outValid=1, out=snapshot[index], outChan=index.
  - On accept (valid&ready): index increments; after CHANNELS-1 is accepted, the FSM returns to IDLE and outValid=0 in the next cycle.
  - out/outChan are stable while outValid&!outReady.
- Latency: first word is valid 1 clk after the wrap edge. With outReady held high, CHANNELS words arrive on consecutive clks.
- Wrap while in SEND (including the cycle of the final accept): the new snapshot is dropped, the bank is unchanged, overrun is set to 1 and stays 1 until rst.
- en=0: filters and counter frozen; the output handshake continues regardless of en.
- Arithmetic:
  - All subtractions are exact within the given widths; no overflow by construction.
  - The |e| of the most negative value saturates to FS.

Optional Feature:
- Macro SD_MAG_PEAK_EN.
- Defined: each channel keeps a peak register, updated each en cycle with max(peak, mag). At wrap the snapshot captures max(peak, mag) and the peak is cleared to 0 in the same edge; reported values are the window peak.
- Undefined: no peak registers; the snapshot is the instantaneous mag at wrap.

Decomposition:
- Package sd_mag_pkg:
  - function ch_bits(n) = max(1, clog2(n)), which defines CH_BITS;
  - fs(width) constant;
  - FSM state encoding IDLE=0, SEND=1.
- Sub-module sd_mag_channel: one channel's two-stage integrator (plus peak register when SD_MAG_PEAK_EN), instantiated CHANNELS times in a generate loop.
- Top level holds the decimation counter, snapshot bank, FSM and overrun.

Test Plan:
- Reset hold: rst=1 for 3 clks with in toggling -> out=0, outChan=0, outValid=0, overrun=0; no word appears until the first wrap after rst falls.
- Settling (defaults): ch0 constant 1, ch1 alternating 1010, ch2 pattern 1110, ch3 constant 0, outReady=1, 8192 clks -> final snapshot reads ch0=32767±64, ch1<=300, ch2=16383±600, ch3=32767±64, with outChan 0,1,2,3 on consecutive clks.
- Backpressure: outReady=0 after the first wrap -> outValid stays 1, outChan=0 and out are stable across the next wrap; overrun=1 from that wrap; releasing ready delivers the original 4 words.
- Enable gating: en high 1 clk in 4 -> words arrive every 256 clks; magnitudes match the en=1 run at equal enabled-cycle counts.
- Reset mid-SEND: outReady=0, assert rst at word 2 -> outValid=0 the next clk, overrun=0, accumulators 0.
- Peak (SD_MAG_PEAK_EN): ch0 settled at all-ones, switched to all-zeros-mean (1010) mid-window -> that window reports ch0=32767±64, and the next windows decay toward <=300.
